// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-stage controller. Owns the program counter, issues instruction-memory
// requests over a variable-latency req/ack handshake and presents fetched
// instructions to decode over a valid/ready handshake. Taken branches/jumps
// redirect the PC in any state; a redirect that lands while a fetch is still
// outstanding drains that fetch and discards its data. Debug support:
// run/halt, single-step and a PC breakpoint.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   run                  level, free-running fetch permitted
//   step                 pulse, fetch one instruction while halted
//   bp_en, bp_addr       breakpoint enable / PC
//   redirect_valid/_pc   taken branch/jump and its target
//   imem_req/_addr       instruction memory request and address
//   imem_ack/_rdata      memory data valid (may coincide with req) and word
//   if_valid/_ready      instruction handshake to decode
//   if_pc, if_instr      PC and word of the presented instruction
//   pc                   current fetch PC
//   halted               controller is in HALT
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic        step,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        step_mode_q, step_mode_d;
  logic        bp_latch_q, bp_latch_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_HALT;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      if_pc_q     <= 32'd0;
      if_instr_q  <= 32'd0;
      step_mode_q <= 1'b0;
      bp_latch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      step_mode_q <= step_mode_d;
      bp_latch_q  <= bp_latch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    step_mode_d = step_mode_q;
    // A breakpoint hit stays latched only while run is held high, so the
    // debugger resumes by toggling run.
    bp_latch_d  = run ? bp_latch_q : 1'b0;

    case (state_q)
      S_HALT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (step) begin
          step_mode_d = 1'b1;
          state_d     = S_FETCH;
        end else if (run && !bp_latch_q) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // Ack this cycle closes the stale transaction; otherwise it must
          // still be drained before a new request can go out.
          state_d = imem_ack ? S_FETCH : S_DRAIN;
        end else if (imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = S_OUT;
        end
      end

      S_OUT: begin
        if (redirect_valid) begin
          // Presented instruction is squashed. In step mode it was never
          // delivered, so fetch again rather than halting.
          pc_d = redirect_pc;
          if (step_mode_q) begin
            state_d = S_FETCH;
          end else if (!run) begin
            state_d = S_HALT;
          end else if (bp_en && (redirect_pc == bp_addr)) begin
            state_d    = S_HALT;
            bp_latch_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else if (if_ready) begin
          // Breakpoint compares against the next fetch PC so the
          // instruction at bp_addr is never fetched before halting.
          if (step_mode_q) begin
            state_d     = S_HALT;
            step_mode_d = 1'b0;
          end else if (!run) begin
            state_d = S_HALT;
          end else if (bp_en && (pc_q == bp_addr)) begin
            state_d    = S_HALT;
            bp_latch_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = (!run && !step_mode_q) ? S_HALT : S_FETCH;
        end
      end

      default: state_d = S_HALT;
    endcase

    // The request address follows the PC whenever a fetch is (re)issued and
    // is frozen otherwise, which keeps the stale address stable in DRAIN.
    addr_d = (state_d == S_FETCH) ? pc_d : addr_q;
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr = addr_q;
  assign if_valid  = (state_q == S_OUT);
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rstn;
  logic        run;
  logic        step;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: ack after ack_lat cycles of continuous request.
  int          ack_lat;
  int          wait_cnt;
  logic [31:0] exp_q[$];

  fetch_sequencer #(
    .RESET_PC(32'h0000_3000),
    .PC_STEP (32'd4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .run           (run),
    .step          (step),
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .pc            (pc),
    .halted        (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = imem_req && (wait_cnt >= ack_lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge rstn) begin
    if (!rstn)                    wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted, non-squashed instruction is popped here.
  always @(negedge clk) begin
    if (rstn && if_valid && if_ready && !redirect_valid) begin
      check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("deliver_pc", if_pc, e);
        check_eq("deliver_instr", if_instr, mem_word(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_halted(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!halted && n < max_cyc) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0; ack_lat = 0;
    #3;
    check_eq("rst_halted", {31'd0, halted}, 32'd1);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_pc", pc, 32'h3000);
    check_eq("rst_addr", imem_addr, 32'h3000);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    ack_lat = 0;
    run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
    #1;

    // Free-running sequential fetch, zero-latency memory.
    apply_reset();
    if_ready = 1'b1;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004); exp_q.push_back(32'h3008);
    run = 1'b1;
    check_eq("seq_halt_before", {31'd0, halted}, 32'd1);
    tick(1);
    check_eq("seq_halt_fall", {31'd0, halted}, 32'd0);
    check_eq("seq_addr0", imem_addr, 32'h3000);
    tick(2);
    check_eq("seq_addr1", imem_addr, 32'h3004);
    tick(2);
    check_eq("seq_addr2", imem_addr, 32'h3008);
    run = 1'b0;
    wait_halted("seq_halt", 10);
    check_eq("seq_pc_end", pc, 32'h300C);
    check_eq("seq_sb_empty", exp_q.size(), 32'd0);

    // Slow memory and decode back-pressure.
    apply_reset();
    ack_lat = 3;
    exp_q.push_back(32'h3000);
    run = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check_eq("slow_req", {31'd0, imem_req}, 32'd1);
      check_eq("slow_addr", imem_addr, 32'h3000);
      tick(1);
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("bp_valid", {31'd0, if_valid}, 32'd1);
      check_eq("bp_noreq", {31'd0, imem_req}, 32'd0);
      check_eq("bp_if_pc", if_pc, 32'h3000);
      check_eq("bp_if_instr", if_instr, mem_word(32'h3000));
      tick(1);
    end
    run = 1'b0;
    if_ready = 1'b1;
    wait_halted("slow_halt", 5);
    check_eq("slow_sb_empty", exp_q.size(), 32'd0);

    // Redirect while a fetch is in flight: drain stale data.
    apply_reset();
    if_ready = 1'b1;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004); exp_q.push_back(32'h4000);
    run = 1'b1;
    tick(4);
    ack_lat = 2;
    tick(1);
    check_eq("drn_fetch_addr", imem_addr, 32'h3008);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000;
    tick(1);
    redirect_valid = 1'b0;
    check_eq("drn_req", {31'd0, imem_req}, 32'd1);
    check_eq("drn_addr_a", imem_addr, 32'h3008);
    check_eq("drn_pc", pc, 32'h4000);
    tick(1);
    check_eq("drn_addr_b", imem_addr, 32'h3008);
    ack_lat = 0;
    tick(1);
    check_eq("drn_new_addr", imem_addr, 32'h4000);
    check_eq("drn_new_req", {31'd0, imem_req}, 32'd1);
    run = 1'b0;
    wait_halted("drn_halt", 10);
    check_eq("drn_pc_end", pc, 32'h4004);
    check_eq("drn_sb_empty", exp_q.size(), 32'd0);

    // Redirect while presenting: squash.
    apply_reset();
    if_ready = 1'b1;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h5000);
    run = 1'b1;
    tick(4);
    check_eq("sq_valid_pre", {31'd0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h5000;
    tick(1);
    redirect_valid = 1'b0;
    check_eq("sq_valid", {31'd0, if_valid}, 32'd0);
    check_eq("sq_addr", imem_addr, 32'h5000);
    run = 1'b0;
    wait_halted("sq_halt", 10);
    check_eq("sq_pc_end", pc, 32'h5004);
    check_eq("sq_sb_empty", exp_q.size(), 32'd0);

    // Breakpoint at 0x300C.
    apply_reset();
    if_ready = 1'b1;
    bp_en = 1'b1;
    bp_addr = 32'h300C;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004); exp_q.push_back(32'h3008);
    run = 1'b1;
    tick(1);
    check_eq("brk_running", {31'd0, halted}, 32'd0);
    wait_halted("brk_halt", 20);
    check_eq("brk_pc", pc, 32'h300C);
    check_eq("brk_sb_empty", exp_q.size(), 32'd0);
    tick(5);
    check_eq("brk_stay_halted", {31'd0, halted}, 32'd1);
    check_eq("brk_stay_noreq", {31'd0, imem_req}, 32'd0);
    run = 1'b0;
    tick(1);
    exp_q.push_back(32'h300C); exp_q.push_back(32'h3010);
    run = 1'b1;
    tick(1);
    check_eq("brk_resume_addr", imem_addr, 32'h300C);
    tick(2);
    run = 1'b0;
    wait_halted("brk_resume_halt", 10);
    check_eq("brk_resume_pc", pc, 32'h3014);
    check_eq("brk_resume_sb", exp_q.size(), 32'd0);

    // Single-step from halt.
    apply_reset();
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h3000 + 32'(4 * k));
      step = 1'b1;
      tick(1);
      step = 1'b0;
      check_eq("step_leave_halt", {31'd0, halted}, 32'd0);
      wait_halted("step_halt", 10);
      check_eq("step_pc", pc, 32'h3004 + 32'(4 * k));
      tick(3);
      check_eq("step_still_halted", {31'd0, halted}, 32'd1);
      check_eq("step_sb_empty", exp_q.size(), 32'd0);
    end

    // Asynchronous reset in the middle of a fetch.
    apply_reset();
    if_ready = 1'b1;
    exp_q.push_back(32'h3000);
    run = 1'b1;
    tick(2);
    ack_lat = 5;
    tick(1);
    check_eq("arst_pre_req", {31'd0, imem_req}, 32'd1);
    check_eq("arst_pre_pc", pc, 32'h3004);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_req", {31'd0, imem_req}, 32'd0);
    check_eq("arst_pc", pc, 32'h3000);
    check_eq("arst_halted", {31'd0, halted}, 32'd1);
    check_eq("arst_addr", imem_addr, 32'h3000);
    run = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick(2);

    check_eq("final_sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller that owns and sequences the program counter. It issues instruction-memory requests over a req/ack handshake with variable latency and hands fetched instructions to decode over a valid/ready handshake. It applies branch/jump redirects, including redirects that arrive while a fetch is still in flight. It also supports debug run/halt, single-step and a PC breakpoint for the board-level debug unit.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
run  input  1  level; 1 = free-running fetch permitted
step  input  1  single-cycle pulse; fetch exactly one instruction while halted
bp_en  input  1  breakpoint enable
bp_addr  input  32  breakpoint PC
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
imem_req  output  1  instruction memory request
imem_addr  output  32  fetch address
imem_ack  input  1  memory data valid; may arrive in the same cycle as req
imem_rdata  input  32  instruction word
if_valid  output  1  fetched instruction valid to decode
if_ready  input  1  decode accepts instruction
if_pc  output  32  PC of the presented instruction
if_instr  output  32  presented instruction
pc  output  32  current fetch PC register
halted  output  1  1 when in HALT state

Behaviour:
- Reset (async, rstn=0): state=HALT; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; if_valid=0; if_pc=0; if_instr=0; halted=1; bp_latch=0; step_mode=0.
- States:
  - HALT: halted=1, imem_req=0.
  - FETCH: imem_req=1, imem_addr=pc.
  - OUT: if_valid=1, imem_req=0.
  - DRAIN: imem_req=1 with the stale address held; waiting for an ack whose data is discarded.
- HALT exit:
  - step=1 → step_mode=1, go to FETCH; the breakpoint is ignored for this fetch.
  - Otherwise run=1 and bp_latch=0 → go to FETCH; the breakpoint is ignored for the first fetch only.
- bp_latch clears whenever run=0.
- FETCH:
  - imem_req stays high and imem_addr stays stable until imem_ack.
  - On ack: if_instr<=imem_rdata, if_pc<=pc, pc<=pc+PC_STEP (mod 2^32), go to OUT.
  - Ack in the cycle FETCH is entered is legal, giving 1-cycle fetch latency (req to if_valid).
- OUT:
  - if_valid, if_pc and if_instr are held stable until if_ready.
  - On if_ready, choose the next state:
    - step_mode=1 → HALT, step_mode<=0.
    - run=0 → HALT.
    - bp_en=1 and pc==bp_addr → HALT, bp_latch<=1.
    - Otherwise → FETCH.
  - The breakpoint check uses the next fetch PC; the instruction at bp_addr is not fetched before halting.
- Redirect (redirect_valid=1) has the highest priority; pc<=redirect_pc in every state.
  - HALT: stay in HALT.
  - FETCH with imem_ack=1: discard the data, stay in FETCH with the new pc.
  - FETCH with imem_ack=0: go to DRAIN; imem_addr keeps the old address until ack.
  - DRAIN: stay in DRAIN; the pc is overwritten again by the newer redirect.
  - OUT: if_valid<=0 next cycle (squash), even if if_ready=1 this cycle; go to FETCH, with halt conditions evaluated as in OUT.
  - After a redirect, step_mode is preserved, so a step still yields one delivered instruction.
- DRAIN: on imem_ack, drop the data and go to FETCH at pc. If run=0 and step_mode=0, go to HALT instead.
- run dropping during FETCH or DRAIN does not abort the memory transaction; the halt takes effect at the next OUT or DRAIN completion.
- step while not halted is ignored.
- No combinational path from if_ready to imem_req; imem_req and if_valid are registered state decodes.

Test Plan:
- Reset then run=1, imem_ack tied 1, if_ready=1 → imem_addr 0x3000, 0x3004, 0x3008 on consecutive fetches; if_pc matches; halted falls 1 cycle after run.
- Ack delayed 3 cycles, if_ready low for 2 cycles in OUT → imem_addr stable 0x3000 for 4 cycles; if_instr/if_pc stable while if_valid=1 and if_ready=0; no new req until accept.
- Redirect to 0x4000 during FETCH of 0x3008 with ack 2 cycles later → DRAIN holds addr 0x3008; its data never appears on if_valid; next req addr=0x4000.
- Redirect to 0x5000 while in OUT with if_ready=1 → presented instruction squashed (if_valid=0 next cycle); next fetch 0x5000.
- bp_en=1, bp_addr=0x300C, run=1 → instructions 0x3000–0x3008 delivered, halted=1, pc=0x300C. run held high → stays halted. run 0 then 1 → fetches 0x300C and continues.
- Halted at 0x3000, three step pulses → exactly one instruction per pulse (0x3000, 0x3004, 0x3008), HALT after each. Async rstn low mid-FETCH → imem_req=0, pc=0x3000 immediately.
